semafor_masini_ctrl: RTL and testbench

Car traffic-light controller for the pedestrian crossing. It registers the pedestrian push-button and ends car green once the minimum green time has elapsed. It then sequences car yellow and an all-red guard interval, and hands the crossing to the downstream pedestrian-light block through an `enable` / `done` / `clear` handshake. After the pedestrian block reports `done`, the controller acknowledges with `clear` and returns car traffic to green.

---
 rtl/semafor_masini_ctrl_pkg.sv | 18 +
 rtl/semafor_masini_ctrl_gen_tick_sec.sv | 34 +++
 rtl/semafor_masini_ctrl.sv | 148 ++++++++++++++
 tb/tb_semafor_masini_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/semafor_masini_ctrl_pkg.sv
// ---- semafor_pkg : state encoding and counter-width helper for the crossing controller (rev 1.0)
`default_nettype none

package semafor_pkg;

  localparam logic [2:0] S_VERDE   = 3'd0;
  localparam logic [2:0] S_GALBEN  = 3'd1;
  localparam logic [2:0] S_GARDA   = 3'd2;
  localparam logic [2:0] S_PIETONI = 3'd3;
  localparam logic [2:0] S_CLEAR   = 3'd4;

  function automatic int latime_cnt(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/semafor_masini_ctrl_gen_tick_sec.sv
// ---- gen_tick_sec : one-cycle pulse every DIV_FACTOR_SEC cycles, zeroed by restart (rev 1.0)
`default_nettype none

module gen_tick_sec
  import semafor_pkg::*;
#(
  parameter int DIV_FACTOR_SEC = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam int              W       = latime_cnt(DIV_FACTOR_SEC - 1);
  localparam logic [W-1:0]    C_ULTIM = W'(DIV_FACTOR_SEC - 1);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt_q <= '0;
    end else if (cnt_q == C_ULTIM) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign tick = (cnt_q == C_ULTIM);

endmodule

`default_nettype wire

// File: rtl/semafor_masini_ctrl.sv
// ---- semafor_masini_ctrl : car-light controller handing the crossing to the pedestrian block (rev 1.0)
// ---- optional build macro: SEMAFOR_TIMEOUT_PIETON_EN enables the pedestrian-phase watchdog
`default_nettype none

module semafor_masini_ctrl
  import semafor_pkg::*;
#(
  parameter int SECUNDE_VERDE_MIN = 12,
  parameter int SECUNDE_GALBEN    = 3,
  parameter int SECUNDE_GARDA     = 2,
  parameter int SECUNDE_TIMEOUT   = 30,
  parameter int DIV_FACTOR_SEC    = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic buton_pieton,
  input  logic pieton_done,
  output logic pieton_enable,
  output logic pieton_clear,
  output logic masina_verde,
  output logic masina_galben,
  output logic masina_rosu,
  output logic cerere_activa,
  output logic eroare
);

  localparam int C_MAX_A = (SECUNDE_VERDE_MIN > SECUNDE_GALBEN) ? SECUNDE_VERDE_MIN : SECUNDE_GALBEN;
  localparam int C_MAX_B = (SECUNDE_GARDA > SECUNDE_TIMEOUT) ? SECUNDE_GARDA : SECUNDE_TIMEOUT;
  localparam int C_MAX   = (C_MAX_A > C_MAX_B) ? C_MAX_A : C_MAX_B;
  localparam int SW      = latime_cnt(C_MAX);

  localparam logic [SW-1:0] C_VERDE      = SW'(SECUNDE_VERDE_MIN);
  localparam logic [SW-1:0] C_VERDE_ULT  = SW'(SECUNDE_VERDE_MIN - 1);
  localparam logic [SW-1:0] C_GALBEN_ULT = SW'(SECUNDE_GALBEN - 1);
  localparam logic [SW-1:0] C_GARDA_ULT  = SW'(SECUNDE_GARDA - 1);
`ifdef SEMAFOR_TIMEOUT_PIETON_EN
  localparam logic [SW-1:0] C_TIMEOUT_ULT = SW'(SECUNDE_TIMEOUT - 1);
`endif

  logic [2:0]    sync_q;
  logic          buton_edge;
  logic          cerere_q, cerere_d;
  logic [2:0]    stare_q, stare_d;
  logic [SW-1:0] sec_q, sec_d;
  logic          tick;
  logic          restart;
  logic          verde_gata;
  logic          timeout_evt;
  logic          verde_q, galben_q, rosu_q, enable_q, clear_q;

  gen_tick_sec #(
    .DIV_FACTOR_SEC(DIV_FACTOR_SEC)
  ) u_tick (
    .clk    (clk),
    .rst    (rst),
    .restart(restart),
    .tick   (tick)
  );

  // sync_q[2] is the previous synchronized level, used only for edge detection
  assign buton_edge = sync_q[1] & ~sync_q[2];
  assign verde_gata = (sec_q == C_VERDE) || (tick && (sec_q == C_VERDE_ULT));
  assign restart    = (stare_d != stare_q);

  always_comb begin
    timeout_evt = 1'b0;
`ifdef SEMAFOR_TIMEOUT_PIETON_EN
    timeout_evt = (stare_q == S_PIETONI) && !pieton_done && tick && (sec_q == C_TIMEOUT_ULT);
`endif
    stare_d = stare_q;
    case (stare_q)
      S_VERDE:   if (cerere_q && verde_gata) stare_d = S_GALBEN;
      S_GALBEN:  if (tick && (sec_q == C_GALBEN_ULT)) stare_d = S_GARDA;
      S_GARDA:   if (tick && (sec_q == C_GARDA_ULT)) stare_d = S_PIETONI;
      S_PIETONI: if (pieton_done || timeout_evt) stare_d = S_CLEAR;
      S_CLEAR:   stare_d = S_VERDE;
      default:   stare_d = S_VERDE;
    endcase
  end

  always_comb begin
    sec_d = sec_q;
    if (restart) begin
      sec_d = '0;
    end else if (tick && !((stare_q == S_VERDE) && (sec_q == C_VERDE))) begin
      sec_d = sec_q + SW'(1);
    end
  end

  always_comb begin
    cerere_d = cerere_q;
    if (stare_q == S_CLEAR) begin
      cerere_d = 1'b0;
    end else if (buton_edge && ((stare_q == S_VERDE) || (stare_q == S_GALBEN))) begin
      cerere_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '0;
      cerere_q <= 1'b0;
      stare_q  <= S_VERDE;
      sec_q    <= '0;
      verde_q  <= 1'b1;
      galben_q <= 1'b0;
      rosu_q   <= 1'b0;
      enable_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[1:0], buton_pieton};
      cerere_q <= cerere_d;
      stare_q  <= stare_d;
      sec_q    <= sec_d;
      verde_q  <= (stare_d == S_VERDE);
      galben_q <= (stare_d == S_GALBEN);
      rosu_q   <= (stare_d != S_VERDE) && (stare_d != S_GALBEN);
      enable_q <= (stare_d == S_PIETONI);
      clear_q  <= (stare_d == S_CLEAR);
    end
  end

`ifdef SEMAFOR_TIMEOUT_PIETON_EN
  logic eroare_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      eroare_q <= 1'b0;
    end else if (timeout_evt) begin
      eroare_q <= 1'b1;
    end
  end

  assign eroare = eroare_q;
`else
  assign eroare = 1'b0;
`endif

  assign masina_verde  = verde_q;
  assign masina_galben = galben_q;
  assign masina_rosu   = rosu_q;
  assign pieton_enable = enable_q;
  assign pieton_clear  = clear_q;
  assign cerere_activa = cerere_q;

endmodule

`default_nettype wire

// File: tb/tb_semafor_masini_ctrl.sv
// ---- tb_semafor_masini_ctrl : scoreboard bench for the crossing controller (rev 1.0)
`default_nettype none

module tb_semafor_masini_ctrl;

  // Output vector bits: {verde, galben, rosu, enable, clear, cerere, eroare}
  localparam logic [6:0] V  = 7'b1000000;
  localparam logic [6:0] G  = 7'b0100000;
  localparam logic [6:0] R  = 7'b0010000;
  localparam logic [6:0] EN = 7'b0001000;
  localparam logic [6:0] CL = 7'b0000100;
  localparam logic [6:0] RQ = 7'b0000010;
  localparam logic [6:0] ER = 7'b0000001;

  typedef struct {
    int         cyc;
    logic [6:0] exp;
    string      name;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic buton_pieton = 1'b0;
  logic pieton_done = 1'b0;
  logic pieton_enable, pieton_clear;
  logic masina_verde, masina_galben, masina_rosu;
  logic cerere_activa, eroare;
  logic [6:0] outv;

  int cyc = 0;
  int base = 0;
  int checks = 0;
  int errors = 0;
  item_t sb[$];

  semafor_masini_ctrl #(
    .SECUNDE_VERDE_MIN(3),
    .SECUNDE_GALBEN   (2),
    .SECUNDE_GARDA    (1),
    .SECUNDE_TIMEOUT  (5),
    .DIV_FACTOR_SEC   (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .buton_pieton (buton_pieton),
    .pieton_done  (pieton_done),
    .pieton_enable(pieton_enable),
    .pieton_clear (pieton_clear),
    .masina_verde (masina_verde),
    .masina_galben(masina_galben),
    .masina_rosu  (masina_rosu),
    .cerere_activa(cerere_activa),
    .eroare       (eroare)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign outv = {masina_verde, masina_galben, masina_rosu, pieton_enable,
                 pieton_clear, cerere_activa, eroare};

  always @(negedge clk) begin
    item_t it;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      it = sb.pop_front();
      checks++;
      if (it.cyc != cyc) begin
        errors++;
        $display("FAIL %s: check for cycle %0d missed (now %0d)", it.name, it.cyc - base, cyc - base);
      end else if (outv !== it.exp) begin
        errors++;
        $display("FAIL %s cycle %0d: got %b, want %b (v g r en clr req err)",
                 it.name, cyc - base, outv, it.exp);
      end
    end
  end

  task automatic exp_rng(input int a, input int b, input logic [6:0] v, input string nm);
    item_t it;
    for (int k = a; k <= b; k++) begin
      it.cyc  = base + k;
      it.exp  = v;
      it.name = nm;
      sb.push_back(it);
    end
  endtask

  task automatic goto(input int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    buton_pieton = 1'b0;
    pieton_done  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    base = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d items pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    // Idle: no button, green holds
    do_reset();
    exp_rng(0, 199, V, "idle_green");
    goto(200);

    // Early press during cycles 1-2, full pedestrian cycle
    do_reset();
    exp_rng(0, 3, V, "early_pre_req");
    exp_rng(4, 11, V | RQ, "early_req_green");
    exp_rng(12, 19, G | RQ, "early_yellow");
    exp_rng(20, 23, R | RQ, "early_guard");
    exp_rng(24, 30, R | EN | RQ, "early_ped");
    exp_rng(31, 31, R | CL | RQ, "early_clear");
    exp_rng(32, 111, V, "early_back_green");
    goto(1);  buton_pieton = 1'b1;
    goto(3);  buton_pieton = 1'b0;
    goto(30); pieton_done = 1'b1;
    goto(32); pieton_done = 1'b0;
    goto(112);

    // Late press, stray done in yellow, press dropped around CLEAR
    do_reset();
    exp_rng(0, 42, V, "late_pre_req");
    exp_rng(43, 43, V | RQ, "late_req_rise");
    exp_rng(44, 51, G | RQ, "late_yellow");
    exp_rng(52, 55, R | RQ, "late_guard");
    exp_rng(56, 60, R | EN | RQ, "late_ped");
    exp_rng(61, 61, R | CL | RQ, "late_clear");
    exp_rng(62, 261, V, "dropped_req_green");
    goto(40); buton_pieton = 1'b1;
    goto(41); buton_pieton = 1'b0;
    goto(45); pieton_done = 1'b1;
    goto(48); pieton_done = 1'b0;
    goto(59); buton_pieton = 1'b1;
    goto(60); pieton_done = 1'b1;
    goto(62); pieton_done = 1'b0;
    goto(70); buton_pieton = 1'b0;
    goto(262);

    // done already high in the first cycle of the pedestrian phase
    do_reset();
    exp_rng(12, 19, G | RQ, "first_yellow");
    exp_rng(20, 23, R | RQ, "first_guard");
    exp_rng(24, 24, R | EN | RQ, "first_ped");
    exp_rng(25, 25, R | CL | RQ, "first_clear");
    exp_rng(26, 40, V, "first_green");
    goto(1);  buton_pieton = 1'b1;
    goto(3);  buton_pieton = 1'b0;
    goto(24); pieton_done = 1'b1;
    goto(26); pieton_done = 1'b0;
    goto(41);

    // Pedestrian block never reports done
    do_reset();
    exp_rng(12, 19, G | RQ, "nodone_yellow");
`ifdef SEMAFOR_TIMEOUT_PIETON_EN
    exp_rng(24, 43, R | EN | RQ, "timeout_ped");
    exp_rng(44, 44, R | CL | RQ | ER, "timeout_clear");
    exp_rng(45, 48, V | ER, "timeout_green");
    exp_rng(49, 56, V | RQ | ER, "sticky_req_green");
    exp_rng(57, 59, G | RQ | ER, "sticky_yellow");
    exp_rng(60, 80, V, "reset_in_yellow");
    goto(1);  buton_pieton = 1'b1;
    goto(3);  buton_pieton = 1'b0;
    goto(46); buton_pieton = 1'b1;
    goto(47); buton_pieton = 1'b0;
    goto(59); rst = 1'b1;
    goto(60); rst = 1'b0;
    goto(81);
`else
    exp_rng(24, 223, R | EN | RQ, "wait_ped");
    exp_rng(224, 224, R | EN | RQ, "wait_ped_done");
    exp_rng(225, 225, R | CL | RQ, "wait_clear");
    exp_rng(226, 240, V, "wait_green");
    goto(1);   buton_pieton = 1'b1;
    goto(3);   buton_pieton = 1'b0;
    goto(224); pieton_done = 1'b1;
    goto(226); pieton_done = 1'b0;
    goto(241);
`endif

    // Reset asserted mid-yellow
    do_reset();
    exp_rng(12, 14, G | RQ, "rst_yellow");
    exp_rng(15, 40, V, "rst_values_green");
    goto(1);  buton_pieton = 1'b1;
    goto(3);  buton_pieton = 1'b0;
    goto(14); rst = 1'b1;
    goto(15); rst = 1'b0;
    goto(41);

    repeat (3) @(posedge clk);
    while (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: check for cycle %0d never evaluated", sb[0].cyc - base);
      void'(sb.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
